control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 4, width of instruction opcode field.
REQ-002 SHALL have parameter T_WIDTH, default 3, width of T-state counter.
REQ-003 SHALL have port i_clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_step  input  1  clock enable; state advances only when high.
REQ-006 SHALL have port i_opcode  input  OPCODE_WIDTH  upper nibble of instruction register.
REQ-007 SHALL have bus-drive outputs, each 1 bit: o_a_reg_out, o_b_reg_out, o_alu_out, o_ram_out, o_instruction_reg_out, o_program_counter_out.
REQ-008 SHALL have load/strobe outputs, each 1 bit: o_mar_in, o_ir_in, o_a_in, o_b_in, o_out_in, o_pc_inc, o_pc_load, o_alu_sub.
REQ-009 SHALL have o_halt  output  1  sticky halted flag; o_t_state  output  T_WIDTH  current T-state.

Function
REQ-010 SHALL be a Moore machine: all control outputs decoded combinationally from registered T-state, opcode and halt only.
REQ-011 SHALL sequence T0..T4 (0..4); T-state increments per enabled cycle, returns to T0 after the opcode's last step (early termination).
REQ-012 SHALL decode T0: o_program_counter_out, o_mar_in.
REQ-013 SHALL decode T1: o_ram_out, o_ir_in, o_pc_inc; opcode sampled from T2 onward.
REQ-014 SHALL decode LDA (0x0): T2 o_instruction_reg_out+o_mar_in; T3 o_ram_out+o_a_in; end.
REQ-015 SHALL decode ADD (0x1): T2 o_instruction_reg_out+o_mar_in; T3 o_ram_out+o_b_in; T4 o_alu_out+o_a_in; end.
REQ-016 SHALL decode SUB (0x2): as ADD with o_alu_sub also high in T4 only.
REQ-017 SHALL decode LDI (0x5): T2 o_instruction_reg_out+o_a_in; end.
REQ-018 SHALL decode JMP (0x6): T2 o_instruction_reg_out+o_pc_load; end.
REQ-019 SHALL decode OUT (0xE): T2 o_a_reg_out+o_out_in; end.
REQ-020 SHALL decode HLT (0xF): T2 no strobes; set halt register at end of T2.
REQ-021 SHALL treat all other opcodes as NOP: return to T0 after T1.
REQ-022 SHALL hold T-state and halt unchanged when i_step low; outputs remain those of held state.
REQ-023 SHALL, while halted, drive every bus-drive and load output low, freeze T-state, ignore i_step; exit only via reset.
REQ-024 SHALL assert at most one bus-drive output in any cycle, for every opcode and T-state.
REQ-025 SHALL never assert o_pc_inc and o_pc_load in the same cycle.
REQ-026 SHALL output o_t_state equal to the registered T-state.

Reset
REQ-027 SHALL on i_reset_n low immediately force T-state=0, halt=0, regardless of i_step or mid-instruction position.
REQ-028 SHALL, during and after reset until first enabled edge, present T0 decode (o_program_counter_out=1, o_mar_in=1, all others 0, o_halt=0).
REQ-029 SHALL resume from T0 on first enabled rising edge after i_reset_n deasserts.

Structure
REQ-030 SHALL place opcode constants, T-state encodings and last-step-per-opcode table in a shared package/header used by the bench.
REQ-031 SHALL contain one combinational sub-module, control_decode, mapping {halt, t_state, opcode} to the control word; sequencer holds counter and halt register.

Verification
REQ-032 Reset, i_step=1, opcode 0x0 -> T0..T3 in 4 cycles, T3 shows o_ram_out+o_a_in, cycle 5 back to T0.
REQ-033 Opcode 0x2 -> five cycles; o_alu_sub=1 only in T4 with o_alu_out+o_a_in; o_t_state sequence 0,1,2,3,4,0.
REQ-034 Opcode 0xF at T2 -> o_halt=1 next cycle, all strobes 0, T-state frozen for 20 cycles despite i_step=1; reset clears.
REQ-035 i_step toggled 1,0,0,1 during ADD T3 -> T3 outputs held two extra cycles, then T4.
REQ-036 Assert i_reset_n=0 asynchronously mid-ADD T4 -> outputs switch to T0 decode before next clock edge.
REQ-037 Random opcodes for 1000 cycles -> assertion: one-hot-or-zero bus drives, no pc_inc with pc_load.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared constants for the control sequencer: opcodes, T-state encodings,
// the control word layout and the last T-state of each opcode.
package control_sequencer_pkg;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic a_reg_out;
        logic b_reg_out;
        logic alu_out;
        logic ram_out;
        logic ir_out;
        logic pc_out;
        logic mar_in;
        logic ir_in;
        logic a_in;
        logic b_in;
        logic out_in;
        logic pc_inc;
        logic pc_load;
        logic alu_sub;
    } ctrl_word_t;

    // Unlisted opcodes behave as NOP and finish after the fetch (T1).
    function automatic logic [2:0] last_step(input logic [3:0] op);
        logic [2:0] last;
        case (op)
            OP_LDA:                         last = T3;
            OP_ADD, OP_SUB:                 last = T4;
            OP_LDI, OP_JMP, OP_OUT, OP_HLT: last = T2;
            default:                        last = T1;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/control_sequencer_control_decode.sv
// Purely combinational map from {halt, T-state, opcode} to the control word.
module control_decode
    import control_sequencer_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4,
    parameter int T_WIDTH      = 3
) (
    input  logic                    halt,
    input  logic [T_WIDTH-1:0]      t_state,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output ctrl_word_t              ctrl
);

    logic [3:0] op;
    logic [2:0] t;

    always_comb begin
        ctrl = '0;
        op   = 4'(opcode);
        t    = 3'(t_state);
        if (!halt) begin
            case (t)
                T0: begin
                    ctrl.pc_out = 1'b1;
                    ctrl.mar_in = 1'b1;
                end
                T1: begin
                    ctrl.ram_out = 1'b1;
                    ctrl.ir_in   = 1'b1;
                    ctrl.pc_inc  = 1'b1;
                end
                default: begin
                    case (op)
                        OP_LDA: begin
                            if (t == T2) begin
                                ctrl.ir_out = 1'b1;
                                ctrl.mar_in = 1'b1;
                            end else if (t == T3) begin
                                ctrl.ram_out = 1'b1;
                                ctrl.a_in    = 1'b1;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            if (t == T2) begin
                                ctrl.ir_out = 1'b1;
                                ctrl.mar_in = 1'b1;
                            end else if (t == T3) begin
                                ctrl.ram_out = 1'b1;
                                ctrl.b_in    = 1'b1;
                            end else if (t == T4) begin
                                ctrl.alu_out = 1'b1;
                                ctrl.a_in    = 1'b1;
                                ctrl.alu_sub = (op == OP_SUB);
                            end
                        end
                        OP_LDI: begin
                            if (t == T2) begin
                                ctrl.ir_out = 1'b1;
                                ctrl.a_in   = 1'b1;
                            end
                        end
                        OP_JMP: begin
                            if (t == T2) begin
                                ctrl.ir_out  = 1'b1;
                                ctrl.pc_load = 1'b1;
                            end
                        end
                        OP_OUT: begin
                            if (t == T2) begin
                                ctrl.a_reg_out = 1'b1;
                                ctrl.out_in    = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Instruction control sequencer: T-state counter, opcode latch and sticky halt,
// with all control outputs decoded from registered state (Moore).
//
// state | meaning
// T0    | fetch address: PC onto bus, load MAR
// T1    | fetch: RAM into IR, increment PC; NOP ends here
// T2    | execute step 1 (HLT sets halt at its end and freezes here)
// T3    | execute step 2 (LDA last step)
// T4    | execute step 3 (ADD/SUB last step)
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4,
    parameter int T_WIDTH      = 3
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_step,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    output logic                    o_a_reg_out,
    output logic                    o_b_reg_out,
    output logic                    o_alu_out,
    output logic                    o_ram_out,
    output logic                    o_instruction_reg_out,
    output logic                    o_program_counter_out,
    output logic                    o_mar_in,
    output logic                    o_ir_in,
    output logic                    o_a_in,
    output logic                    o_b_in,
    output logic                    o_out_in,
    output logic                    o_pc_inc,
    output logic                    o_pc_load,
    output logic                    o_alu_sub,
    output logic                    o_halt,
    output logic [T_WIDTH-1:0]      o_t_state
);

    logic [T_WIDTH-1:0]      t_state_q, t_state_d;
    logic                    halt_q, halt_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [OPCODE_WIDTH-1:0] opcode_eff;
    logic [2:0]              last_t;
    logic                    step_en;
    ctrl_word_t              ctrl;

    // During T1 the IR is being loaded, so the end-of-fetch decision (NOP or not)
    // has to look at the incoming opcode rather than the latched one.
    always_comb begin
        step_en    = i_step & ~halt_q;
        opcode_eff = (t_state_q == T_WIDTH'(T1)) ? i_opcode : opcode_q;
        last_t     = last_step(4'(opcode_eff));
        t_state_d  = t_state_q;
        halt_d     = halt_q;
        opcode_d   = opcode_q;
        if (step_en) begin
            if (t_state_q == T_WIDTH'(T1)) begin
                opcode_d = i_opcode;
            end
            if (t_state_q >= T_WIDTH'(last_t)) begin
                if (4'(opcode_eff) == OP_HLT) begin
                    halt_d = 1'b1;
                end else begin
                    t_state_d = '0;
                end
            end else begin
                t_state_d = t_state_q + T_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            t_state_q <= '0;
            halt_q    <= 1'b0;
            opcode_q  <= '0;
        end else begin
            t_state_q <= t_state_d;
            halt_q    <= halt_d;
            opcode_q  <= opcode_d;
        end
    end

    control_decode #(
        .OPCODE_WIDTH(OPCODE_WIDTH),
        .T_WIDTH     (T_WIDTH)
    ) u_control_decode (
        .halt   (halt_q),
        .t_state(t_state_q),
        .opcode (opcode_q),
        .ctrl   (ctrl)
    );

    assign o_a_reg_out           = ctrl.a_reg_out;
    assign o_b_reg_out           = ctrl.b_reg_out;
    assign o_alu_out             = ctrl.alu_out;
    assign o_ram_out             = ctrl.ram_out;
    assign o_instruction_reg_out = ctrl.ir_out;
    assign o_program_counter_out = ctrl.pc_out;
    assign o_mar_in              = ctrl.mar_in;
    assign o_ir_in               = ctrl.ir_in;
    assign o_a_in                = ctrl.a_in;
    assign o_b_in                = ctrl.b_in;
    assign o_out_in              = ctrl.out_in;
    assign o_pc_inc              = ctrl.pc_inc;
    assign o_pc_load             = ctrl.pc_load;
    assign o_alu_sub             = ctrl.alu_sub;
    assign o_halt                = halt_q;
    assign o_t_state             = t_state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: instruction table, stall, async
// reset, halt and a random run checking bus-drive exclusivity.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    localparam logic [13:0] M_A_REG_OUT = 14'h2000;
    localparam logic [13:0] M_B_REG_OUT = 14'h1000;
    localparam logic [13:0] M_ALU_OUT   = 14'h0800;
    localparam logic [13:0] M_RAM_OUT   = 14'h0400;
    localparam logic [13:0] M_IR_OUT    = 14'h0200;
    localparam logic [13:0] M_PC_OUT    = 14'h0100;
    localparam logic [13:0] M_MAR_IN    = 14'h0080;
    localparam logic [13:0] M_IR_IN     = 14'h0040;
    localparam logic [13:0] M_A_IN      = 14'h0020;
    localparam logic [13:0] M_B_IN      = 14'h0010;
    localparam logic [13:0] M_OUT_IN    = 14'h0008;
    localparam logic [13:0] M_PC_INC    = 14'h0004;
    localparam logic [13:0] M_PC_LOAD   = 14'h0002;
    localparam logic [13:0] M_ALU_SUB   = 14'h0001;

    localparam logic [13:0] W_T0 = M_PC_OUT | M_MAR_IN;
    localparam logic [13:0] W_T1 = M_RAM_OUT | M_IR_IN | M_PC_INC;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_step = 1'b0;
    logic [3:0] i_opcode = 4'h0;
    logic o_a_reg_out, o_b_reg_out, o_alu_out, o_ram_out, o_instruction_reg_out;
    logic o_program_counter_out, o_mar_in, o_ir_in, o_a_in, o_b_in, o_out_in;
    logic o_pc_inc, o_pc_load, o_alu_sub, o_halt;
    logic [2:0] o_t_state;

    control_sequencer #(.OPCODE_WIDTH(4), .T_WIDTH(3)) dut (
        .i_clk                 (i_clk),
        .i_reset_n             (i_reset_n),
        .i_step                (i_step),
        .i_opcode              (i_opcode),
        .o_a_reg_out           (o_a_reg_out),
        .o_b_reg_out           (o_b_reg_out),
        .o_alu_out             (o_alu_out),
        .o_ram_out             (o_ram_out),
        .o_instruction_reg_out (o_instruction_reg_out),
        .o_program_counter_out (o_program_counter_out),
        .o_mar_in              (o_mar_in),
        .o_ir_in               (o_ir_in),
        .o_a_in                (o_a_in),
        .o_b_in                (o_b_in),
        .o_out_in              (o_out_in),
        .o_pc_inc              (o_pc_inc),
        .o_pc_load             (o_pc_load),
        .o_alu_sub             (o_alu_sub),
        .o_halt                (o_halt),
        .o_t_state             (o_t_state)
    );

    always #5 i_clk = ~i_clk;

    logic [17:0] act;
    assign act = {o_halt, o_t_state, o_a_reg_out, o_b_reg_out, o_alu_out, o_ram_out,
                  o_instruction_reg_out, o_program_counter_out, o_mar_in, o_ir_in,
                  o_a_in, o_b_in, o_out_in, o_pc_inc, o_pc_load, o_alu_sub};

    typedef struct {
        logic [3:0]        op;
        int                n;
        logic [4:0][13:0]  w;
    } vec_t;

    vec_t        vecs[9];
    logic [17:0] sb_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic vec_t mk(input logic [3:0] op, input int n,
                                input logic [13:0] w2, input logic [13:0] w3,
                                input logic [13:0] w4);
        vec_t v;
        v.op = op;
        v.n  = n;
        v.w  = {w4, w3, w2, W_T1, W_T0};
        return v;
    endfunction

    task automatic expect_st(input logic h, input logic [2:0] t, input logic [13:0] w);
        sb_q.push_back({h, t, w});
    endtask

    task automatic check(input string name);
        logic [17:0] e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got halt=%b t=%0d ctrl=%h, want halt=%b t=%0d ctrl=%h",
                         name, act[17], act[16:14], act[13:0], e[17], e[16:14], e[13:0]);
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset_n = 1'b0;
        i_step    = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        expect_st(1'b0, T0, W_T0);
        check("reset_active");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        expect_st(1'b0, T0, W_T0);
        check("reset_released");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(OP_LDA, 4, M_IR_OUT | M_MAR_IN, M_RAM_OUT | M_A_IN, '0);
        vecs[1] = mk(OP_ADD, 5, M_IR_OUT | M_MAR_IN, M_RAM_OUT | M_B_IN, M_ALU_OUT | M_A_IN);
        vecs[2] = mk(OP_SUB, 5, M_IR_OUT | M_MAR_IN, M_RAM_OUT | M_B_IN,
                     M_ALU_OUT | M_A_IN | M_ALU_SUB);
        vecs[3] = mk(OP_LDI, 3, M_IR_OUT | M_A_IN, '0, '0);
        vecs[4] = mk(OP_JMP, 3, M_IR_OUT | M_PC_LOAD, '0, '0);
        vecs[5] = mk(OP_OUT, 3, M_A_REG_OUT | M_OUT_IN, '0, '0);
        vecs[6] = mk(4'h3, 2, '0, '0, '0);
        vecs[7] = mk(4'h7, 2, '0, '0, '0);
        vecs[8] = mk(OP_SUB, 5, M_IR_OUT | M_MAR_IN, M_RAM_OUT | M_B_IN,
                     M_ALU_OUT | M_A_IN | M_ALU_SUB);

        do_reset();

        // Back-to-back instructions from the table.
        for (int i = 0; i < 9; i++) begin
            i_opcode = vecs[i].op;
            for (int k = 0; k < vecs[i].n; k++) begin
                expect_st(1'b0, 3'(k), vecs[i].w[k]);
                check($sformatf("vec%0d_op%h_t%0d", i, vecs[i].op, k));
                tick();
            end
        end
        expect_st(1'b0, T0, W_T0);
        check("table_end_t0");

        // ADD with step held low for two edges in T3.
        i_opcode = OP_ADD;
        expect_st(1'b0, T0, W_T0);                 check("stall_t0"); tick();
        expect_st(1'b0, T1, W_T1);                 check("stall_t1"); tick();
        expect_st(1'b0, T2, M_IR_OUT | M_MAR_IN);  check("stall_t2"); tick();
        expect_st(1'b0, T3, M_RAM_OUT | M_B_IN);   check("stall_t3");
        i_step = 1'b0;
        tick();
        expect_st(1'b0, T3, M_RAM_OUT | M_B_IN);   check("stall_hold1");
        tick();
        expect_st(1'b0, T3, M_RAM_OUT | M_B_IN);   check("stall_hold2");
        i_step = 1'b1;
        tick();
        expect_st(1'b0, T4, M_ALU_OUT | M_A_IN);   check("stall_t4");
        tick();
        expect_st(1'b0, T0, W_T0);                 check("stall_back_t0");

        // Asynchronous reset in the middle of ADD T4.
        repeat (4) tick();
        expect_st(1'b0, T4, M_ALU_OUT | M_A_IN);   check("areset_at_t4");
        #2;
        i_reset_n = 1'b0;
        #1;
        expect_st(1'b0, T0, W_T0);                 check("areset_immediate");
        tick();
        expect_st(1'b0, T0, W_T0);                 check("areset_held");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        tick();
        expect_st(1'b0, T1, W_T1);                 check("areset_resume_t1");

        // HLT: sticky halt, frozen T-state, everything low.
        do_reset();
        i_opcode = OP_HLT;
        expect_st(1'b0, T0, W_T0);                 check("hlt_t0"); tick();
        expect_st(1'b0, T1, W_T1);                 check("hlt_t1"); tick();
        expect_st(1'b0, T2, '0);                   check("hlt_t2"); tick();
        i_opcode = OP_ADD;
        for (int c = 0; c < 20; c++) begin
            expect_st(1'b1, T2, '0);
            check($sformatf("hlt_frozen_%0d", c));
            tick();
        end
        do_reset();

        // Random opcodes and step: bus drives one-hot-or-zero, no inc with load.
        for (int c = 0; c < 1000; c++) begin
            if (c % 150 == 149) begin
                do_reset();
            end
            i_opcode = 4'($urandom_range(0, 15));
            i_step   = ($urandom_range(0, 3) != 0);
            tick();
            n_cmp++;
            if (($countones(act[13:8]) > 1) || (o_pc_inc && o_pc_load) ||
                (o_halt && (act[13:0] != '0))) begin
                n_fail++;
                $display("FAIL random_%0d: ctrl=%h halt=%b t=%0d", c, act[13:0], o_halt, o_t_state);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
